// File: rtl/lifo_buffer.sv
// Parametrised LIFO with replace-top, empty bypass, combinational peek,
// occupancy decode, sticky overflow/underflow flags and a pop strobe.
module lifo_buffer #(
  parameter int DEPTH     = 8,
  parameter int BANDWIDTH = 4,
  parameter int AF_LEVEL  = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BANDWIDTH-1:0] data_in,
  output logic [BANDWIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic [BANDWIDTH-1:0] top,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [BANDWIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]        ptr_q, ptr_d;
  logic [BANDWIDTH-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 we;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        top_idx;
  logic [BANDWIDTH-1:0] top_ent;

  assign top_idx = AW'(ptr_q - CW'(1));
  assign top_ent = mem[top_idx];

  assign count       = ptr_q;
  assign full        = (ptr_q == CW'(DEPTH));
  assign empty       = (ptr_q == '0);
  assign almost_full = (ptr_q >= CW'(AF_LEVEL));
  assign top         = empty ? '0 : top_ent;
  assign data_out    = dout_q;
  assign valid_out   = valid_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  always_comb begin
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    wr_idx  = ptr_q[AW-1:0];
    if (clr) begin
      ptr_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            ptr_d = ptr_q + CW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = top_ent;
            ptr_d   = ptr_q - CW'(1);
            valid_d = 1'b1;
          end
        end
        2'b11: begin
          // Empty: data bypasses storage; otherwise the top slot is swapped in place.
          valid_d = 1'b1;
          if (empty) begin
            dout_d = data_in;
          end else begin
            dout_d = top_ent;
            we     = 1'b1;
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ptr_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_lifo_buffer.sv
// Directed, table-driven bench for lifo_buffer (DEPTH=8, BANDWIDTH=4, AF_LEVEL=7).
module tb_lifo_buffer;

  localparam int DEPTH = 8;
  localparam int BW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn, clr, push, pop;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out, top;
  logic          valid_out, full, empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  lifo_buffer #(.DEPTH(DEPTH), .BANDWIDTH(BW), .AF_LEVEL(DEPTH - 1)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
    .top(top), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pu, po, cl;
    logic [BW-1:0] din;
    logic [CW-1:0] cnt;
    logic [BW-1:0] tp, dq;
    logic          v, f, e, af, ov, un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pu, po, cl, input logic [BW-1:0] din,
                              input int cnt, input logic [BW-1:0] tp, dq,
                              input logic v, f, e, af, ov, un);
    vec_t r;
    r.pu = pu; r.po = po; r.cl = cl; r.din = din;
    r.cnt = CW'(cnt); r.tp = tp; r.dq = dq;
    r.v = v; r.f = f; r.e = e; r.af = af; r.ov = ov; r.un = un;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t x);
    chk("count", idx, 32'(count), 32'(x.cnt));
    chk("top", idx, 32'(top), 32'(x.tp));
    chk("data_out", idx, 32'(data_out), 32'(x.dq));
    chk("valid_out", idx, 32'(valid_out), 32'(x.v));
    chk("full", idx, 32'(full), 32'(x.f));
    chk("empty", idx, 32'(empty), 32'(x.e));
    chk("almost_full", idx, 32'(almost_full), 32'(x.af));
    chk("overflow", idx, 32'(overflow), 32'(x.ov));
    chk("underflow", idx, 32'(underflow), 32'(x.un));
  endtask

  task automatic drive(input logic pu, po, cl, input logic [BW-1:0] d);
    @(negedge clk);
    push = pu; pop = po; clr = cl; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                pu po cl din cnt top dout v  f  e  af ov un
    vecs.push_back(mk(1, 0, 0, 4'h1, 1, 4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h2, 2, 4'h2, 4'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h3, 3, 4'h3, 4'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 2, 4'h2, 4'h3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 1, 4'h1, 4'h2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h1, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h5, 1, 4'h5, 4'h1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 0, 4'h0, 4'h1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h4, 1, 4'h4, 4'h1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h6, 2, 4'h6, 4'h1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'hA, 2, 4'hA, 4'h6, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 2, 4'hA, 4'h6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 0, 4'h0, 4'h6, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'hC, 0, 4'h0, 4'hC, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk(1, 0, 0, BW'(i), i + 1, BW'(i), 4'hC, 0,
                        (i == DEPTH - 1), 0, (i + 1 >= DEPTH - 1), 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'hB, 8, 4'hB, 4'h7, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h9, 8, 4'hB, 4'h7, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 4'h9, 0, 4'h0, 4'h7, 0, 0, 1, 0, 0, 0));

    rstn = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    rstn = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pu, vecs[i].po, vecs[i].cl, vecs[i].din);
      chk_all(i, vecs[i]);
    end

    // Asynchronous reset asserted between edges, then underflow after release.
    drive(1, 0, 0, 4'h1);
    drive(1, 0, 0, 4'h2);
    drive(0, 1, 0, 4'h0);
    chk_all(100, mk(0, 0, 0, 4'h0, 1, 4'h1, 4'h2, 1, 0, 0, 0, 0, 0));
    #2 rstn = 1'b1;
    #1;
    chk_all(101, mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    rstn = 1'b0;
    drive(0, 1, 0, 4'h0);
    chk_all(102, mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 1));

    // Mid-cycle input wiggle must not change state before the next edge.
    @(negedge clk);
    push = 1'b1; data_in = 4'hE;
    #2 push = 1'b0;
    @(posedge clk);
    #1;
    chk_all(103, mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_buffer.md
# lifo_buffer

Parametrised LIFO buffer. Successor to the basic stack used across the design.
- Adds simultaneous push/pop (replace-top) and a combinational peek of the top entry.
- Adds an occupancy count, an almost-full threshold, sticky overflow/underflow error flags, a one-cycle read-valid strobe and a synchronous clear.
- Sits between a producer issuing push and a consumer issuing pop, both on one clock domain.

## Interface
Parameters:
- DEPTH, 8: number of entries; must be ≥ 2.
- BANDWIDTH, 4: data width in bits; must be ≥ 1.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-high reset. Asserting it (1) resets immediately, regardless of clk.
- clr  in  1  synchronous clear; highest priority after reset.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  BANDWIDTH  data written on push.
- data_out  out  BANDWIDTH  registered popped data; holds its value until the next successful pop.
- valid_out  out  1  one-cycle strobe; data_out was updated on this edge.
- top  out  BANDWIDTH  combinational peek: entry at the top of the stack when not empty, else 0.
- count  out  CW  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- overflow  out  1  sticky; a push was dropped.
- underflow  out  1  sticky; a pop found no data.

## Operation
Reset (rstn=1), asynchronous:
- ptr=0, data_out=0, valid_out=0, overflow=0, underflow=0.
- Memory contents are not reset; top reads 0 because the stack is empty.

Per rising edge, rstn=0, first matching case applies:
- clr=1: ptr=0, valid_out=0, overflow=0, underflow=0. data_out holds. push/pop ignored.
- push & !pop & !full: mem[ptr]←data_in; ptr+1; valid_out=0.
- push & !pop & full: no write; ptr unchanged; overflow←1; valid_out=0.
- pop & !push & !empty: data_out←mem[ptr-1]; ptr-1; valid_out=1.
- pop & !push & empty: data_out holds; underflow←1; valid_out=0.
- push & pop & !empty (replace-top): data_out←old mem[ptr-1]; mem[ptr-1]←data_in; ptr unchanged; valid_out=1. This is legal when full and sets no flag.
- push & pop & empty (bypass): data_out←data_in; ptr stays 0; valid_out=1; no flag.
- neither push nor pop: state holds; valid_out=0.

Other rules:
- overflow and underflow stay set until reset or clr.
- ptr arithmetic is CW bits wide and never wraps: it saturates at 0 and DEPTH through the guards above.
- count, full, empty and almost_full are decoded combinationally from ptr.
- top is mem[ptr-1] when ptr>0, else {BANDWIDTH{1'b0}}.

## Timing
- Push-to-visible latency is 1 cycle: top and count reflect a push after the edge that accepts it.
- Pop latency is 1 cycle: data_out and valid_out update on the accepting edge. valid_out is high for exactly that cycle.
- Back-to-back pushes or pops are accepted every cycle with no bubbles.
- Inputs are sampled only at the rising edge; changes between edges have no effect.
- rstn asserted mid-operation clears outputs within the same cycle, with no clk edge needed. Deassertion takes effect at the next edge. Stored data is treated as lost.
- full, empty, almost_full, count and top change only after clock edges or reset, never combinationally from push/pop.

## Test plan
- Reset, then push 1,2,3 on consecutive cycles → count=3, top=3, empty=0. Pop ×3 → data_out 3,2,1 with valid_out=1 each cycle; then empty=1, top=0.
- Push 0..7 (DEPTH=8) → full=1 and almost_full=1 from count=7. Push 9 → overflow=1, count=8, top=7. clr → count=0, overflow=0.
- From empty, pop → underflow=1, valid_out=0, data_out unchanged. Push 5 → underflow still 1.
- With stack [4,6], push=pop=1, data_in=A → data_out=6, valid_out=1, count=2, top=A. Repeat on a full stack → overflow stays 0.
- Empty stack, push=pop=1, data_in=C → data_out=C, valid_out=1, count=0, empty=1.
- Push 2 values, raise rstn mid-cycle between edges → count=0, data_out=0, valid_out=0 immediately. After release, first pop flags underflow.
